// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pulse_pkg
// Purpose : Shared state encodings, widths and defaults for the pulse
//           transmitter and its hold counter.
// Revision: 1.0 - initial release
// ============================================================================
package pulse_pkg;

  // Counter / pulse-count width; also the width of the HOLD parameter.
  localparam int C_CNT_W = 4;

  // Default number of enabled cycles each output level is held.
  localparam logic [C_CNT_W-1:0] C_HOLD_DEFAULT = 4'd12;

  // Transmitter states; the fourth encoding (3) is illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Terminal value of the hold counter for a given hold length.
  function automatic logic [C_CNT_W-1:0] last_cnt(input logic [C_CNT_W-1:0] hold);
    return hold - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hold_cnt.sv
`default_nettype none
// ============================================================================
// Module  : hold_cnt
// Purpose : Enabled up-counter that times how long the transmitter holds
//           each output level; tc flags the last cycle of a hold period.
// Revision: 1.0 - initial release
// ============================================================================
module hold_cnt
  import pulse_pkg::*;
#(
  parameter logic [C_CNT_W-1:0] HOLD = C_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [C_CNT_W-1:0] r_cnt;

  // Count enabled cycles; a clear request wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      if (clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Terminal count is decoded straight from the register so the FSM sees
  // it in the same cycle the counter reaches HOLD-1.
  assign tc = (r_cnt == last_cnt(HOLD));

endmodule
`default_nettype wire

// File: rtl/pulse_tx.sv
`default_nettype none
// ============================================================================
// Module  : pulse_tx
// Purpose : Transmits a train of num pulses, each HOLD enabled cycles high
//           followed by HOLD enabled cycles low, with a registered
//           completion strobe and a synchronous abort.
// Revision: 1.0 - initial release
// ============================================================================
module pulse_tx
  import pulse_pkg::*;
#(
  parameter logic [C_CNT_W-1:0] HOLD = C_HOLD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [C_CNT_W-1:0] num,
  input  logic               abort,
  output logic               y,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  state_t             w_next;
  logic [C_CNT_W-1:0] r_remaining;
  logic               r_y;
  logic               r_done;

  logic               w_tc;
  logic               w_clr;
  logic               w_accept;
  logic               w_last;
  logic               w_low_end;

  // A request is only taken in IDLE, with a non-zero count and no abort.
  assign w_accept  = (r_state == ST_IDLE) && start && (num != '0) && !abort;

  // End of a LOW hold period: either start the next pulse or finish.
  assign w_low_end = (r_state == ST_LOW) && w_tc;

  // Final pulse of the train; remaining==0 cannot occur in LOW but is
  // treated as final so the FSM can never get stuck cycling.
  assign w_last    = w_low_end && (r_remaining <= 4'd1);

  // Hold counter restarts on every state change and is parked at zero in IDLE.
  assign w_clr     = abort || (w_next != r_state) || (r_state == ST_IDLE);

  hold_cnt #(
    .HOLD (HOLD)
  ) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (w_clr),
    .tc  (w_tc)
  );

  // Next-state decode; abort overrides everything, illegal codes recover.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_next = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tc) begin
            w_next = ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_tc) begin
            w_next = w_last ? ST_IDLE : ST_HIGH;
          end
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register, advanced only on enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  // Registered outputs and pulse bookkeeping; done is a one-cycle strobe
  // that drops on every edge where it is not explicitly set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y         <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_done <= 1'b0;
      if (en) begin
        // y tracks the state being entered so it rises on the accepting edge.
        r_y    <= (w_next == ST_HIGH);
        r_done <= w_last && !abort;
        if (abort) begin
          r_remaining <= '0;
        end else if (w_accept) begin
          r_remaining <= num;
        end else if (w_low_end) begin
          r_remaining <= w_last ? '0 : (r_remaining - 4'd1);
        end
      end
    end
  end

  assign y    = r_y;
  assign done = r_done;
  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_pulse_tx
// Purpose : Directed self-checking bench for pulse_tx (HOLD=12).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pulse_tx;

  localparam int H = 12;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       en    = 1'b1;
  logic       start = 1'b0;
  logic [3:0] num   = 4'd0;
  logic       abort = 1'b0;
  logic       y;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_bad = 0;

  pulse_tx #(
    .HOLD (4'd12)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .num   (num),
    .abort (abort),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {y,busy,done} in cycle c after accepting an n-pulse train with en=1.
  function automatic logic [2:0] model(input int c, input int n);
    logic yy, bb, dd;
    bb = (c >= 1) && (c <= 2 * H * n);
    yy = bb && (((c - 1) % (2 * H)) < H);
    dd = (c == 2 * H * n + 1);
    return {yy, bb, dd};
  endfunction

  // Accept a train of n pulses at the next edge and check ncyc cycles;
  // at cycle poke (if non-zero) a start with num=5 is driven while busy.
  task automatic run_train(input int n, input int ncyc, input int poke, input string tag);
    start = 1'b1;
    num   = n[3:0];
    tick;
    start = 1'b0;
    num   = 4'd0;
    for (int c = 1; c <= ncyc; c++) begin
      chk($sformatf("%s c%0d", tag, c), {29'd0, y, busy, done}, {29'd0, model(c, n)});
      if (c == poke) begin
        start = 1'b1;
        num   = 4'd5;
      end else begin
        start = 1'b0;
        num   = 4'd0;
      end
      tick;
    end
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst y", {31'd0, y}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick;
    chk("post rst", {29'd0, y, busy, done}, 32'd0);

    // start with num=0 in IDLE is ignored.
    start = 1'b1;
    num   = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("num0 %0d", i), {29'd0, y, busy, done}, 32'd0);
    end
    start = 1'b0;

    // Single pulse: y 1..12, busy 1..24, done in 25.
    run_train(1, 28, 0, "n1");

    // Three pulses with an ignored start while busy.
    run_train(3, 78, 5, "n3");

    // num=1 with en alternating: each level spans 24 clocks, done in 49.
    start = 1'b1;
    num   = 4'd1;
    tick;
    start = 1'b0;
    num   = 4'd0;
    for (int c = 1; c <= 52; c++) begin
      chk($sformatf("en c%0d", c), {29'd0, y, busy, done},
          {29'd0, (c <= 24), (c <= 48), (c == 49)});
      en = (c <= 48) ? (c % 2 == 0) : 1'b1;
      tick;
    end
    en = 1'b1;

    // Abort in cycle 30 of a 3-pulse train, then IDLE-only stimulus.
    start = 1'b1;
    num   = 4'd3;
    tick;
    start = 1'b0;
    num   = 4'd0;
    for (int c = 1; c <= 60; c++) begin
      chk($sformatf("abort c%0d", c), {29'd0, y, busy, done},
          (c <= 30) ? {29'd0, model(c, 3)} : 32'd0);
      abort = 1'b0;
      start = 1'b0;
      num   = 4'd0;
      if (c == 30) begin
        abort = 1'b1;
      end else if (c >= 40 && c <= 45) begin
        start = 1'b1;
      end else if (c == 50) begin
        start = 1'b1;
        num   = 4'd2;
        abort = 1'b1;
      end
      tick;
    end
    abort = 1'b0;
    start = 1'b0;

    // Asynchronous reset in the middle of the first HIGH level.
    start = 1'b1;
    num   = 4'd2;
    tick;
    start = 1'b0;
    num   = 4'd0;
    repeat (4) tick;
    chk("pre arst", {29'd0, y, busy, done}, 32'b110);
    #3 rst = 1'b1;
    #1;
    chk("arst y", {31'd0, y}, 32'd0);
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    #2 rst = 1'b0;
    tick;
    chk("arst idle", {29'd0, y, busy, done}, 32'd0);

    // Two full pulses after the reset.
    run_train(2, 52, 0, "after rst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
